// File: rtl/uart_frame_decoder.sv
// Frame decoder behind the UART receiver: sync / length / payload / XOR checksum,
// then replays a verified payload on a valid/ready byte stream.
//
// state         | meaning
// --------------+-------------------------------------------------------------
// S_WAIT_SYNC   | idle, hunting for SYNC_BYTE; other bytes ignored
// S_GET_LEN     | next byte is the payload length
// S_GET_PAYLOAD | storing payload bytes into the buffer, folding the checksum
// S_GET_CSUM    | next byte is compared against the running XOR
// S_DRAIN       | replaying the buffer downstream; incoming bytes are overruns
module uart_frame_decoder #(
  parameter int                   DATA_BITS      = 8,
  parameter int                   MAX_LEN        = 16,
  parameter logic [DATA_BITS-1:0] SYNC_BYTE      = 8'hA5,
  parameter int                   TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i_data_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_byte_valid,
  output logic [DATA_BITS-1:0] o_byte,
  output logic                 o_byte_last,
  input  logic                 i_byte_ready,
  output logic                 o_frame_ok,
  output logic                 o_err_csum,
  output logic                 o_err_len,
  output logic                 o_err_timeout,
  output logic                 o_err_overrun
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LW-1:0] LEN_ONE   = LW'(1);
  localparam logic [CW-1:0] IDLE_LOAD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_ONE  = CW'(1);

  typedef enum logic [4:0] {
    S_WAIT_SYNC   = 5'b00001,
    S_GET_LEN     = 5'b00010,
    S_GET_PAYLOAD = 5'b00100,
    S_GET_CSUM    = 5'b01000,
    S_DRAIN       = 5'b10000
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [LW-1:0]        len_q;
  logic [LW-1:0]        wr_idx;
  logic [LW-1:0]        rd_idx;
  logic [DATA_BITS-1:0] csum;
  logic [CW-1:0]        idle_cnt;
  logic [DATA_BITS-1:0] pay_buf [MAX_LEN];

  logic len_too_big;
  logic len_zero;
  logic csum_match;
  logic idle_expired;
  logic in_frame;
  logic last_wr;
  logic last_rd;

  // length is judged on the whole received byte, before truncation to LW bits
  assign len_too_big  = (int'(i_data) > MAX_LEN);
  assign len_zero     = (i_data == '0);
  assign csum_match   = (i_data == csum);
  assign idle_expired = (idle_cnt == '0);
  assign in_frame     = (state == S_GET_LEN) || (state == S_GET_PAYLOAD) ||
                        (state == S_GET_CSUM);
  assign last_wr      = (wr_idx == len_q - LEN_ONE);
  assign last_rd      = (rd_idx == len_q - LEN_ONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_WAIT_SYNC;
      len_q    <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      csum     <= '0;
      idle_cnt <= '0;
    end else begin
      state <= state_nxt;

      // idle timer is a down-counter reloaded by any byte and outside a frame
      if (i_data_valid || !in_frame) begin
        idle_cnt <= IDLE_LOAD;
      end else if (!idle_expired) begin
        idle_cnt <= idle_cnt - IDLE_ONE;
      end

      if (i_data_valid) begin
        case (state)
          S_GET_LEN: begin
            len_q  <= i_data[LW-1:0];
            csum   <= i_data;
            wr_idx <= '0;
          end
          S_GET_PAYLOAD: begin
            csum   <= csum ^ i_data;
            wr_idx <= wr_idx + LEN_ONE;
          end
          default: ;
        endcase
      end

      if (state == S_DRAIN) begin
        if (i_byte_ready) rd_idx <= rd_idx + LEN_ONE;
      end else begin
        rd_idx <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_GET_PAYLOAD) && i_data_valid) begin
      pay_buf[wr_idx[IW-1:0]] <= i_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT_SYNC: begin
        if (i_data_valid && (i_data == SYNC_BYTE)) state_nxt = S_GET_LEN;
      end
      S_GET_LEN: begin
        if (i_data_valid) begin
          if (len_too_big)   state_nxt = S_WAIT_SYNC;
          else if (len_zero) state_nxt = S_GET_CSUM;
          else               state_nxt = S_GET_PAYLOAD;
        end else if (idle_expired) begin
          state_nxt = S_WAIT_SYNC;
        end
      end
      S_GET_PAYLOAD: begin
        if (i_data_valid) begin
          if (last_wr) state_nxt = S_GET_CSUM;
        end else if (idle_expired) begin
          state_nxt = S_WAIT_SYNC;
        end
      end
      S_GET_CSUM: begin
        if (i_data_valid) begin
          if (csum_match && (len_q != '0)) state_nxt = S_DRAIN;
          else                             state_nxt = S_WAIT_SYNC;
        end else if (idle_expired) begin
          state_nxt = S_WAIT_SYNC;
        end
      end
      S_DRAIN: begin
        if (i_byte_ready && last_rd) state_nxt = S_WAIT_SYNC;
      end
      default: state_nxt = S_WAIT_SYNC;
    endcase
  end

  always_comb begin
    o_byte_valid  = (state == S_DRAIN);
    o_byte        = '0;
    o_byte_last   = 1'b0;
    if (state == S_DRAIN) begin
      o_byte      = pay_buf[rd_idx[IW-1:0]];
      o_byte_last = last_rd;
    end
    o_frame_ok    = (state == S_GET_CSUM) && i_data_valid && csum_match;
    o_err_csum    = (state == S_GET_CSUM) && i_data_valid && !csum_match;
    o_err_len     = (state == S_GET_LEN) && i_data_valid && len_too_big;
    // a byte landing on the expiry cycle takes priority over the timeout
    o_err_timeout = in_frame && !i_data_valid && idle_expired;
    o_err_overrun = (state == S_DRAIN) && i_data_valid;
  end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Sits directly downstream of the UART receiver and consumes its one-cycle byte strobes.
- Hunts for a sync byte, then captures a length byte, a payload and an XOR checksum.
- On a good checksum, replays the buffered payload on a valid/ready byte stream toward the command layer.
- Bad frames are discarded and flagged on one-cycle error pulses.

Parameters:
- DATA_BITS, 8, byte width; must match the receiver.
- MAX_LEN, 16, maximum payload bytes per frame, 1..255.
- SYNC_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CYCLES, 50000, maximum idle clocks between bytes inside a frame.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- i_data_valid  input  1  one-cycle strobe from the UART receiver.
- i_data  input  DATA_BITS  received byte; sampled only when i_data_valid=1.
- o_byte_valid  output  1  payload byte available.
- o_byte  output  DATA_BITS  payload byte.
- o_byte_last  output  1  marks the final payload byte of the frame.
- i_byte_ready  input  1  downstream accepts the byte when high with o_byte_valid.
- o_frame_ok  output  1  one-cycle pulse: checksum matched.
- o_err_csum  output  1  one-cycle pulse: checksum mismatch.
- o_err_len  output  1  one-cycle pulse: length byte > MAX_LEN.
- o_err_timeout  output  1  one-cycle pulse: inter-byte timeout.
- o_err_overrun  output  1  one-cycle pulse: byte arrived during DRAIN and was dropped.

Behaviour:
- Reset (async, n_rst low): state=WAIT_SYNC; all outputs 0; counters and checksum cleared; buffer contents don't-care.
- States are one-hot: WAIT_SYNC, GET_LEN, GET_PAYLOAD, GET_CSUM, DRAIN.
- WAIT_SYNC:
  - i_data_valid with i_data==SYNC_BYTE -> GET_LEN.
  - Any other byte is ignored silently.
- GET_LEN, on a byte:
  - len > MAX_LEN -> pulse o_err_len, go to WAIT_SYNC.
  - len == 0 -> GET_CSUM.
  - otherwise -> GET_PAYLOAD.
  - In all cases: csum <= len, store len, wr_idx <= 0.
- GET_PAYLOAD, on a byte:
  - buf[wr_idx] <= byte; csum ^= byte; wr_idx++.
  - After the byte with wr_idx == len-1 -> GET_CSUM.
- GET_CSUM, on a byte:
  - byte == csum -> pulse o_frame_ok. len > 0 -> DRAIN; len == 0 -> WAIT_SYNC.
  - byte != csum -> pulse o_err_csum, go to WAIT_SYNC.
- DRAIN:
  - First cycle after o_frame_ok: o_byte_valid=1, o_byte=buf[0]; rd_idx starts at 0.
  - o_byte_last=1 exactly when rd_idx == len-1.
  - Handshake completes on o_byte_valid & i_byte_ready, then rd_idx++.
  - o_byte and o_byte_last stay stable while valid & !ready.
  - Handshake with last=1 -> WAIT_SYNC; o_byte_valid=0 next cycle.
- Overrun: the receiver cannot stall, so any i_data_valid in DRAIN drops the byte and pulses o_err_overrun. The frame in progress still drains completely, and that byte is not treated as a sync.
- Timeout:
  - Idle counter clears on every i_data_valid and on entry to GET_LEN.
  - It increments in GET_LEN, GET_PAYLOAD and GET_CSUM.
  - At TIMEOUT_CYCLES-1 with no byte -> pulse o_err_timeout, go to WAIT_SYNC.
  - Inactive in WAIT_SYNC and DRAIN.
  - If a byte and expiry coincide, the byte wins and no timeout fires.
- Sync value inside a frame: a SYNC_BYTE value arriving in GET_LEN, GET_PAYLOAD or GET_CSUM is plain data; there is no resync mid-frame.
- Widths: csum is DATA_BITS; len, wr_idx and rd_idx are $clog2(MAX_LEN+1) bits. The length compare uses the full DATA_BITS byte before truncation. The buffer is MAX_LEN x DATA_BITS registers with a single write port and a single read port.
- Error pulses are mutually exclusive per cycle, except o_err_overrun, which may coincide with nothing else because it only occurs in DRAIN.
- Reset mid-operation: all state is abandoned, and no output pulses occur during or after reset.

Test Plan:
- Good frame: A5,03,11,22,33,checksum 03^11^22^33=03, ready held 1 -> o_frame_ok pulses once; o_byte sequence 11,22,33 on three consecutive cycles starting the cycle after o_frame_ok; o_byte_last only on 33.
- Backpressure: same frame, i_byte_ready low for 5 cycles at byte 22 -> 22 held stable with valid=1, then 33; no bytes lost or duplicated.
- Checksum error: A5,02,AA,BB,00 -> o_err_csum pulses once, o_byte_valid never asserts; an immediately following good frame decodes correctly.
- Length/empty: A5,11 (17 > MAX_LEN) -> o_err_len, return to WAIT_SYNC; A5,00,00 -> o_frame_ok with no payload output.
- Timeout: A5,02,44, then silence for TIMEOUT_CYCLES -> o_err_timeout exactly once, state WAIT_SYNC; a following A5,01,A5,A4 yields payload A5 with o_byte_last=1.
- Overrun/reset: inject a byte while DRAIN is stalled -> o_err_overrun and the frame still completes; assert n_rst mid-payload -> all outputs 0 immediately, and the next good frame decodes.
